alu_issue_stage: RTL and testbench

//   Sequential front-end that accepts ALU commands over a valid/ready handshake, registers

---
 rtl/alu_issue_pkg.sv | 33 +++
 rtl/alu_issue_stage_alu.sv | 57 +++++
 rtl/alu_issue_stage.sv | 127 ++++++++++++
 tb/tb_alu_issue_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
//----------------------------------------------------------------------------
// Module : alu_issue_pkg
// Brief  : Opcode encodings, issue-stage FSM states and flag helper.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package alu_issue_pkg;

  localparam logic [2:0] ADD_  = 3'd0;
  localparam logic [2:0] SUB_  = 3'd1;
  localparam logic [2:0] XOR_  = 3'd2;
  localparam logic [2:0] SLT_  = 3'd3;
  localparam logic [2:0] AND_  = 3'd4;
  localparam logic [2:0] NAND_ = 3'd5;
  localparam logic [2:0] NOR_  = 3'd6;
  localparam logic [2:0] OR_   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Signed overflow: ADD needs equal operand signs, SUB needs differing ones.
  function automatic logic calc_ovf(input logic is_sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    return (((a_msb ^ b_msb) == is_sub) && (r_msb != a_msb));
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_stage_alu.sv
//----------------------------------------------------------------------------
// Module : alu_issue_stage_alu
// Brief  : Combinational ALU (add/sub/slt/logic ops) driven by the issue stage.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage_alu
  import alu_issue_pkg::*;
#(
  parameter int W   = 4,
  parameter int DLY = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   ctrl,
  output logic [W-1:0] r,
  output logic         cout,
  output logic         slt
);

  // DLY characterises gate delay of the physical ALU; this model is zero-delay.
  if (DLY < 0) begin : g_dly_check
    $error("DLY must be non-negative");
  end

  logic         w_sub;
  logic [W-1:0] w_bx;
  logic [W:0]   w_sum;
  logic         w_ovf_sub;

  assign w_sub     = (ctrl == SUB_) || (ctrl == SLT_);
  assign w_bx      = w_sub ? ~b : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_bx} + {{W{1'b0}}, w_sub};
  assign w_ovf_sub = (a[W-1] != b[W-1]) && (w_sum[W-1] != a[W-1]);
  assign slt       = w_sum[W-1] ^ w_ovf_sub;

  always_comb begin
    r    = '0;
    cout = 1'b0;
    case (ctrl)
      ADD_, SUB_: begin
        r    = w_sum[W-1:0];
        cout = w_sum[W];
      end
      XOR_:    r = a ^ b;
      SLT_:    r = {{(W-1){1'b0}}, slt};
      AND_:    r = a & b;
      NAND_:   r = ~(a & b);
      NOR_:    r = ~(a | b);
      default: r = a | b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
//----------------------------------------------------------------------------
// Module : alu_issue_stage
// Brief  : Valid/ready issue stage that holds ALU inputs for SETTLE_CYC
//          cycles, then captures the result and flags for write-back.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int W          = 4,
  parameter int DLY        = 5,
  parameter int SETTLE_CYC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_ctrl,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero,
  output logic [7:0]   op_count
);

  localparam int CW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 1) begin : g_settle_check
    $error("SETTLE_CYC must be at least 1");
  end

  state_t       r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]   r_ctrl;
  logic [W-1:0] r_a, r_b;
  logic [W-1:0] r_out_r;
  logic         r_out_valid, r_out_cout, r_out_ovf, r_out_zero;
  logic [7:0]   r_op_count;

  logic [W-1:0] w_alu_r, w_cap_r;
  logic         w_alu_cout, w_alu_slt, w_arith;
  logic         w_accept, w_capture, w_release;

  alu_issue_stage_alu #(.W(W), .DLY(DLY)) u_alu (
    .a    (r_a),
    .b    (r_b),
    .ctrl (r_ctrl),
    .r    (w_alu_r),
    .cout (w_alu_cout),
    .slt  (w_alu_slt)
  );

  assign in_ready  = (r_state == ST_IDLE) && !reset;
  assign w_accept  = in_valid && in_ready;
  assign w_capture = (r_state == ST_SETTLE) && (r_cnt == '0);
  assign w_release = (r_state == ST_HOLD) && out_ready;
  assign w_arith   = (r_ctrl == ADD_) || (r_ctrl == SUB_);
  assign w_cap_r   = (r_ctrl == SLT_) ? {{(W-1){1'b0}}, w_alu_slt} : w_alu_r;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)  w_next = ST_SETTLE;
      ST_SETTLE: if (w_capture) w_next = ST_HOLD;
      ST_HOLD:   if (w_release) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // ALU outputs are sampled only on capture, so settling glitches never escape.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_ctrl      <= ADD_;
      r_a         <= '0;
      r_b         <= '0;
      r_out_r     <= '0;
      r_out_valid <= 1'b0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
      r_op_count  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_ctrl <= in_ctrl;
        r_a    <= in_a;
        r_b    <= in_b;
        r_cnt  <= C_CNT_LOAD;
      end else if ((r_state == ST_SETTLE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_out_r     <= w_cap_r;
        r_out_zero  <= (w_cap_r == '0);
        r_out_cout  <= w_arith && w_alu_cout;
        r_out_ovf   <= w_arith &&
                       calc_ovf(r_ctrl == SUB_, r_a[W-1], r_b[W-1], w_cap_r[W-1]);
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
        r_op_count  <= r_op_count + 8'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign out_zero  = r_out_zero;
  assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
//----------------------------------------------------------------------------
// Module : tb_alu_issue_stage
// Brief  : Directed self-checking bench for alu_issue_stage.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready;
  logic       in_ready, out_valid, out_cout, out_ovf, out_zero;
  logic [2:0] in_ctrl;
  logic [3:0] in_a, in_b, out_r;
  logic [7:0] op_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  alu_issue_stage #(.W(4), .DLY(5), .SETTLE_CYC(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .op_count  (op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, check the 3-cycle latency, then check results.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] er, input logic ec,
                        input logic eo, input logic ez);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0; in_a = ~a; in_b = ~b;
    chk({tag, "_v1"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_v2"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_v3"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_r"},    {28'd0, out_r}, {28'd0, er});
    chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
    chk({tag, "_ovf"},  {31'd0, out_ovf},  {31'd0, eo});
    chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, ez});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk({tag, "_vdone"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, op_count}, {24'd0, exp_cnt});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = 3'd0; in_a = 4'd0; in_b = 4'd0;
    tick();
    tick();
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_r",     {28'd0, out_r}, 32'd0);
    chk("rst_flags",     {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
    chk("rst_op_count",  {24'd0, op_count}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    run_op("add_7_1",  3'd0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
    run_op("sub_3_5",  3'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0);
    run_op("sub_5_3",  3'd1, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0, 1'b0);
    run_op("slt_2_5",  3'd3, 4'h2, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0);
    run_op("slt_5_2",  3'd3, 4'h5, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1);
    run_op("xor_5_5",  3'd2, 4'h5, 4'h5, 4'h0, 1'b0, 1'b0, 1'b1);
    run_op("add_f_1",  3'd0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
    run_op("nand_c_a", 3'd5, 4'hC, 4'hA, 4'h7, 1'b0, 1'b0, 1'b0);
    run_op("nor_c_a",  3'd6, 4'hC, 4'hA, 4'h1, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held, new commands refused.
    in_valid = 1'b1; in_ctrl = 3'd0; in_a = 4'h1; in_b = 4'h2;
    tick();
    in_a = 4'h9; in_b = 4'h9; in_ctrl = 3'd7;
    tick();
    tick();
    chk("bp_valid_start", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_r",     {28'd0, out_r}, 32'd3);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("bp_cnt",   {24'd0, op_count}, {24'd0, exp_cnt});
    chk("bp_done",  {31'd0, out_valid}, 32'd0);
    tick();
    tick();
    tick();
    chk("bp_no_accept", {31'd0, out_valid}, 32'd0);

    // Reset during SETTLE aborts the operation and clears the counter.
    in_valid = 1'b1; in_ctrl = 3'd0; in_a = 4'h2; in_b = 4'h2;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_cnt",   {24'd0, op_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
    end

    // Reset coincident with a handshake discards the handshake.
    in_valid = 1'b1; reset = 1'b1;
    tick();
    in_valid = 1'b0; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hs_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("rst_hs_ready", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
